// File: rtl/minibus_arbiter_if.sv
// Minibus request/response packs and the arbiter's bus bundle.
// Holds NUM_MASTERS master-side pairs, the single decoder-side pair, and the arbiter status signals.
package minibus_pkg;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } minibus_req_pack;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } minibus_res_pack;

endpackage

interface minibus_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    import minibus_pkg::*;

    localparam int GW = $clog2(NUM_MASTERS);

    minibus_req_pack m_req [NUM_MASTERS];
    minibus_res_pack m_res [NUM_MASTERS];
    minibus_req_pack s_req;
    minibus_res_pack s_res;
    logic [GW-1:0]   grant_idx;
    logic            busy;
    logic            timeout_err;

    // The slave view belongs to the arbiter; the master view belongs to the masters and the decoder around it.
    modport slave (
        input  m_req, s_res,
        output m_res, s_req, grant_idx, busy, timeout_err
    );

    modport master (
        output m_req, s_res,
        input  m_res, s_req, grant_idx, busy, timeout_err
    );

endinterface

// File: rtl/minibus_arbiter.sv
// Round-robin arbiter that shares one decoder path among NUM_MASTERS minibus masters.
// The grant is held for a whole transaction, and a watchdog turns a hung transaction into an error response.
module minibus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             nrst,
    minibus_arbiter_if.slave bus
);

    localparam int GW = $clog2(NUM_MASTERS);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_MASTERS - 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t           r_state;
    logic [GW-1:0]    r_grant_idx;
    logic [GW-1:0]    r_last_grant;
    logic [WW-1:0]    r_wdog;

    logic [NUM_MASTERS-1:0] w_req_vec;
    logic             w_found;
    logic [GW-1:0]    w_pick;
    logic             w_gnt_req;
    logic             w_expire;
    logic             w_txn_end;

    // Rotating search: the first requester after last_grant wins, so the master just served goes to the back of the line.
    always_comb begin
        logic [GW-1:0] cand;
        // NOTE: every combinational output gets a default before any conditional write; otherwise a latch is inferred.
        w_req_vec = '0;
        w_found   = 1'b0;
        w_pick    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_req_vec[i] = bus.m_req[i].ren | bus.m_req[i].wen;
        end
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = GW'((int'(r_last_grant) + k) % NUM_MASTERS);
            if (!w_found && w_req_vec[cand]) begin
                w_found = 1'b1;
                w_pick  = cand;
            end
        end
    end

    assign w_gnt_req = w_req_vec[r_grant_idx];
    // An on-time ready always beats the watchdog, and a withdrawn request gets no response of any kind.
    assign w_expire  = (r_state == ST_BUSY) && (r_wdog == WDOG_LAST) && !bus.s_res.ready && w_gnt_req;
    assign w_txn_end = bus.s_res.ready || !w_gnt_req || (r_wdog == WDOG_LAST);

    always_comb begin
        bus.s_req       = '0;
        bus.timeout_err = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            bus.m_res[i] = '0;
        end
        if (r_state == ST_BUSY) begin
            if (w_expire) begin
                bus.m_res[r_grant_idx].ready = 1'b1;
                bus.m_res[r_grant_idx].error = 1'b1;
                bus.timeout_err              = 1'b1;
            end else begin
                bus.s_req                = bus.m_req[r_grant_idx];
                bus.m_res[r_grant_idx]   = bus.s_res;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_grant_idx  <= '0;
            r_last_grant <= LAST_INIT;
            r_wdog       <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values and no ordering race appears.
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant_idx <= w_pick;
                        r_wdog      <= '0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_txn_end) begin
                        r_last_grant <= r_grant_idx;
                        r_wdog       <= '0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state == ST_BUSY);
    assign bus.grant_idx = r_grant_idx;

endmodule

// File: tb/tb_minibus_arbiter.sv
// Self-checking bench for minibus_arbiter: a transaction-level model is compared on every cycle,
// and directed scenarios carry hand-computed expectations.
module tb_minibus_arbiter;
    import minibus_pkg::*;

    localparam int N = 4;
    localparam int T = 8;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    minibus_arbiter_if #(.NUM_MASTERS(N)) bus();

    minibus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Master agents and decoder: each master repeats its template until want[i] responses have been acknowledged.
    int              want [N];
    minibus_req_pack tmpl [N];
    logic [N-1:0]    ack;
    int              slv_wait;
    logic [31:0]     slv_rdata;
    int              slv_cnt;

    initial begin
        for (int i = 0; i < N; i++) begin
            want[i]      = 0;
            tmpl[i]      = '0;
            bus.m_req[i] = '0;
        end
        bus.s_res = '0;
        slv_wait  = 0;
        slv_rdata = '0;
        slv_cnt   = 0;
        ack       = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) ack[i] = bus.m_res[i].ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (ack[i] && want[i] > 0) want[i]--;
                bus.m_req[i] = (want[i] > 0) ? tmpl[i] : '0;
            end
            if (bus.busy) begin
                if (slv_wait >= 0 && slv_cnt == slv_wait)
                    bus.s_res = '{ready: 1'b1, rdata: slv_rdata, error: 1'b0};
                else
                    bus.s_res = '0;
                slv_cnt++;
            end else begin
                slv_cnt   = 0;
                bus.s_res = '0;
            end
        end
    end

    // Reference model: who owns the bus, how many cycles the transaction has run, and who was served last.
    int mo_owner   = -1;
    int mo_elapsed = 0;
    int mo_last    = N - 1;

    function automatic logic is_req(input int i);
        return bus.m_req[i].ren | bus.m_req[i].wen;
    endfunction

    function automatic int rr_pick(input int last);
        for (int off = 1; off <= N; off++) begin
            if (is_req((last + off) % N)) return (last + off) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mo_owner   <= -1;
            mo_elapsed <= 0;
            mo_last    <= N - 1;
        end else if (mo_owner < 0) begin
            if (rr_pick(mo_last) >= 0) begin
                mo_owner   <= rr_pick(mo_last);
                mo_elapsed <= 1;
            end
        end else if (bus.s_res.ready || !is_req(mo_owner) || mo_elapsed == T) begin
            mo_last  <= mo_owner;
            mo_owner <= -1;
        end else begin
            mo_elapsed <= mo_elapsed + 1;
        end
    end

    minibus_req_pack e_sreq;
    minibus_res_pack e_res [N];
    logic            e_to;

    always @(negedge clk) begin
        e_sreq = '0;
        e_to   = 1'b0;
        for (int i = 0; i < N; i++) e_res[i] = '0;
        if (mo_owner >= 0) begin
            if (mo_elapsed == T && !bus.s_res.ready && is_req(mo_owner)) begin
                e_res[mo_owner].ready = 1'b1;
                e_res[mo_owner].error = 1'b1;
                e_to                  = 1'b1;
            end else begin
                e_sreq          = bus.m_req[mo_owner];
                e_res[mo_owner] = bus.s_res;
            end
        end
        check("model_busy", bus.busy, mo_owner >= 0);
        if (mo_owner >= 0) check("model_grant_idx", bus.grant_idx, mo_owner);
        check("model_s_req", bus.s_req, e_sreq);
        for (int i = 0; i < N; i++) check("model_m_res", bus.m_res[i], e_res[i]);
        check("model_timeout_err", bus.timeout_err, e_to);
    end

    task automatic do_reset();
        for (int i = 0; i < N; i++) want[i] = 0;
        slv_wait = 0;
        #2 nrst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 nrst = 1'b1;
        @(negedge clk);
    endtask

    function automatic minibus_req_pack mk_req(input logic wr, input logic [31:0] addr);
        minibus_req_pack r;
        r       = '0;
        r.ren   = !wr;
        r.wen   = wr;
        r.addr  = addr;
        r.wdata = wr ? 32'hCAFE_F00D : 32'h0;
        r.wstrb = wr ? 4'hF : 4'h0;
        return r;
    endfunction

    initial begin
        #1 nrst = 1'b0;
        @(negedge clk);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_grant_idx", bus.grant_idx, 2'd0);
        check("reset_s_req", bus.s_req, 70'h0);
        #2 nrst = 1'b1;
        @(negedge clk);

        // Single read from master 2 with a 2-wait decoder.
        do_reset();
        slv_wait  = 2;
        slv_rdata = 32'hDEAD_BEEF;
        tmpl[2]   = mk_req(1'b0, 32'h100);
        want[2]   = 1;
        @(negedge clk);
        check("rd_t0_busy", bus.busy, 1'b0);
        @(negedge clk);
        check("rd_t1_addr", bus.s_req.addr, 32'h100);
        check("rd_t1_grant", bus.grant_idx, 2'd2);
        @(negedge clk);
        check("rd_t2_ready", bus.m_res[2].ready, 1'b0);
        @(negedge clk);
        check("rd_t3_ready", bus.m_res[2].ready, 1'b1);
        check("rd_t3_rdata", bus.m_res[2].rdata, 32'hDEAD_BEEF);
        check("rd_t3_other_ready", {bus.m_res[0].ready, bus.m_res[1].ready, bus.m_res[3].ready}, 3'b000);
        @(negedge clk);
        check("rd_t4_busy", bus.busy, 1'b0);

        // Masters 1 and 3 together, zero-wait decoder.
        do_reset();
        slv_wait = 0;
        tmpl[1]  = mk_req(1'b0, 32'h111);
        tmpl[3]  = mk_req(1'b0, 32'h333);
        want[1]  = 1;
        want[3]  = 1;
        @(negedge clk);
        @(negedge clk);
        check("pair_t1_grant", bus.grant_idx, 2'd1);
        check("pair_t1_addr", bus.s_req.addr, 32'h111);
        @(negedge clk);
        check("pair_t2_bubble", bus.busy, 1'b0);
        @(negedge clk);
        check("pair_t3_grant", bus.grant_idx, 2'd3);
        check("pair_t3_addr", bus.s_req.addr, 32'h333);

        // All four requesting continuously, 2-wait decoder: 4-cycle rotation.
        do_reset();
        slv_wait = 2;
        for (int i = 0; i < N; i++) begin
            tmpl[i] = mk_req(1'b0, 32'h400 + 32'(i));
            want[i] = 100;
        end
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_grant", bus.grant_idx, k % N);
            check("rr_busy", bus.busy, 1'b1);
            repeat (2) @(negedge clk);
            @(negedge clk);
            check("rr_bubble", bus.busy, 1'b0);
        end

        // Hung decoder: master 0 write times out in its 8th BUSY cycle, then master 1 is granted.
        do_reset();
        slv_wait = -1;
        tmpl[0]  = mk_req(1'b1, 32'h200);
        tmpl[1]  = mk_req(1'b0, 32'h204);
        want[0]  = 1;
        want[1]  = 1;
        @(negedge clk);
        repeat (7) @(negedge clk);
        check("to_t7_ready", bus.m_res[0].ready, 1'b0);
        check("to_t7_pulse", bus.timeout_err, 1'b0);
        @(negedge clk);
        check("to_t8_res", bus.m_res[0], {1'b1, 32'h0, 1'b1});
        check("to_t8_pulse", bus.timeout_err, 1'b1);
        check("to_t8_s_req", bus.s_req, 70'h0);
        @(negedge clk);
        check("to_t9_busy", bus.busy, 1'b0);
        @(negedge clk);
        check("to_t10_grant", bus.grant_idx, 2'd1);
        repeat (9) @(negedge clk);

        // Ready coincides with the last watchdog cycle: normal response wins.
        do_reset();
        slv_wait  = T - 1;
        slv_rdata = 32'h1234_5678;
        tmpl[3]   = mk_req(1'b0, 32'h300);
        want[3]   = 1;
        @(negedge clk);
        repeat (8) @(negedge clk);
        check("edge_t8_res", bus.m_res[3], {1'b1, 32'h1234_5678, 1'b0});
        check("edge_t8_pulse", bus.timeout_err, 1'b0);
        @(negedge clk);
        check("edge_t9_busy", bus.busy, 1'b0);

        // Reset pulse in the middle of master 2's transaction.
        do_reset();
        slv_wait = -1;
        tmpl[2]  = mk_req(1'b0, 32'h500);
        want[2]  = 1;
        @(negedge clk);
        @(negedge clk);
        check("rst_t1_grant", bus.grant_idx, 2'd2);
        @(negedge clk);
        @(negedge clk);
        tmpl[0] = mk_req(1'b0, 32'h600);
        want[0] = 1;
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("rst_async_busy", bus.busy, 1'b0);
        check("rst_async_s_req", bus.s_req, 70'h0);
        check("rst_async_m_res2", bus.m_res[2], 34'h0);
        @(negedge clk);
        #2 nrst = 1'b1;
        @(negedge clk);
        check("rst_after_grant", bus.grant_idx, 2'd0);
        check("rst_after_busy", bus.busy, 1'b1);
        for (int i = 0; i < N; i++) want[i] = 0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
